// File: rtl/psram_pkg.sv
`default_nettype none
// ============================================================================
// Module  : psram_pkg
// Brief   : Shared types, default opcodes and helpers for the QPI PSRAM engine
// Revision: 1.0 - initial release
// ============================================================================
package psram_pkg;

  typedef enum logic [2:0] {
    ST_INIT  = 3'd0,
    ST_IDLE  = 3'd1,
    ST_CMD   = 3'd2,
    ST_ADDR  = 3'd3,
    ST_DUMMY = 3'd4,
    ST_DATA  = 3'd5,
    ST_GAP   = 3'd6
  } state_e;

  localparam logic [7:0] C_CMD_RD  = 8'hEB;
  localparam logic [7:0] C_CMD_WR  = 8'h38;
  localparam logic [7:0] C_CMD_QPI = 8'h35;

  // Each byte travels as two 4-bit beats on the quad bus
  function automatic logic [5:0] nibbles_for_bytes(input logic [3:0] nbytes);
    return {1'b0, nbytes, 1'b0};
  endfunction

endpackage
`default_nettype wire

// File: rtl/psram_sck_gen.sv
`default_nettype none
// ============================================================================
// Module  : psram_sck_gen
// Brief   : clk/2 serial clock for the PSRAM, idle-low while ce_n is high,
//           with strobes marking the clk edge that ends each beat
// Revision: 1.0 - initial release
// ============================================================================
module psram_sck_gen (
  input  logic clk,
  input  logic rst_n,
  input  logic ce_n_i,
  output logic sck_o,
  output logic drive_en_o,
  output logic sample_en_o
);

  logic sck_q;

  // Toggle only while selected so every transaction starts with sck low
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sck_q <= 1'b0;
    end else if (ce_n_i) begin
      sck_q <= 1'b0;
    end else begin
      sck_q <= ~sck_q;
    end
  end

  // The edge that takes sck 1->0 both launches the next nibble and captures din
  assign sck_o       = sck_q;
  assign drive_en_o  = sck_q & ~ce_n_i;
  assign sample_en_o = sck_q & ~ce_n_i;

endmodule
`default_nettype wire

// File: rtl/psram_qspi_engine.sv
`default_nettype none
// ============================================================================
// Module  : psram_qspi_engine
// Brief   : Single-FSM QPI PSRAM transaction engine: serial QPI-enable at
//           power-up, then parametrised quad read/write bursts
// Revision: 1.0 - initial release
// ============================================================================
module psram_qspi_engine
  import psram_pkg::*;
#(
  parameter int         ADDR_W    = 24,
  parameter int         MAX_BYTES = 4,
  parameter int         RD_DUMMY  = 6,
  parameter logic [7:0] CMD_RD    = C_CMD_RD,
  parameter logic [7:0] CMD_WR    = C_CMD_WR,
  parameter logic [7:0] CMD_QPI   = C_CMD_QPI,
  parameter bit         INIT_EN   = 1'b1,
  parameter int         CE_GAP    = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req_i,
  input  logic                   we_i,
  input  logic [ADDR_W-1:0]      addr_i,
  input  logic [3:0]             size_i,
  input  logic [8*MAX_BYTES-1:0] wdata_i,
  output logic [8*MAX_BYTES-1:0] rdata_o,
  output logic                   done_o,
  output logic                   busy_o,
  output logic                   init_done_o,
  output logic                   sck_o,
  output logic                   ce_n_o,
  input  logic [3:0]             din_i,
  output logic [3:0]             dout_o,
  output logic [3:0]             douten_o
);

  // One MSB-aligned shift register serves opcode, address and write data
  localparam int         SR_W    = (ADDR_W > 8 * MAX_BYTES) ? ADDR_W : 8 * MAX_BYTES;
  localparam logic [3:0] C_MAX_B = 4'(MAX_BYTES);
  localparam logic [SR_W-1:0] C_QPI_AL = SR_W'(CMD_QPI) << (SR_W - 8);

  state_e                 state_q;
  logic [5:0]             cnt_q;
  logic [SR_W-1:0]        sr_q;
  logic [3:0]             dout_q;
  logic [3:0]             douten_q;
  logic                   ce_n_q;
  logic                   done_q;
  logic                   busy_q;
  logic                   init_done_q;
  logic [8*MAX_BYTES-1:0] rdata_q;
  logic                   we_q;
  logic [5:0]             nib_q;
  logic [ADDR_W-1:0]      addr_q;
  logic [8*MAX_BYTES-1:0] wdata_q;

  logic                   drive_en;
  logic                   sample_en;
  logic [3:0]             eff_size;
  logic [7:0]             cmd_sel;
  logic [SR_W-1:0]        cmd_al;
  logic [SR_W-1:0]        addr_al;
  logic [SR_W-1:0]        wstream;
  logic [5:0]             rd_idx;

  psram_sck_gen u_sck_gen (
    .clk         (clk),
    .rst_n       (rst_n),
    .ce_n_i      (ce_n_q),
    .sck_o       (sck_o),
    .drive_en_o  (drive_en),
    .sample_en_o (sample_en)
  );

  assign eff_size = ((size_i == 4'd0) || (size_i > C_MAX_B)) ? C_MAX_B : size_i;
  assign cmd_sel  = we_i ? CMD_WR : CMD_RD;
  assign cmd_al   = SR_W'(cmd_sel) << (SR_W - 8);
  assign addr_al  = SR_W'(addr_q) << (SR_W - ADDR_W);
  // Read nibble k lands in byte k/2, high half first: nibble slot is k^1
  assign rd_idx   = (nib_q - 6'd1 - cnt_q) ^ 6'd1;

  // Byte 0 goes to the top of the stream so it leaves the pins first
  always_comb begin
    wstream = '0;
    for (int i = 0; i < MAX_BYTES; i++) begin
      wstream[SR_W-1-8*i -: 8] = wdata_q[8*i +: 8];
    end
  end

  // Transaction sequencer: every phase advances on the beat-ending edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= INIT_EN ? ST_INIT : ST_IDLE;
      cnt_q       <= '0;
      sr_q        <= '0;
      dout_q      <= '0;
      douten_q    <= '0;
      ce_n_q      <= 1'b1;
      done_q      <= 1'b0;
      busy_q      <= INIT_EN;
      init_done_q <= ~INIT_EN;
      rdata_q     <= '0;
      we_q        <= 1'b0;
      nib_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_INIT: begin
          if (ce_n_q) begin
            // First cycle out of reset only selects the device
            ce_n_q   <= 1'b0;
            douten_q <= 4'b0001;
            dout_q   <= {3'b000, CMD_QPI[7]};
            sr_q     <= C_QPI_AL << 1;
            cnt_q    <= 6'd7;
          end else if (drive_en) begin
            if (cnt_q == 6'd0) begin
              state_q  <= ST_GAP;
              ce_n_q   <= 1'b1;
              dout_q   <= '0;
              douten_q <= '0;
              cnt_q    <= 6'(CE_GAP - 1);
            end else begin
              dout_q <= {3'b000, sr_q[SR_W-1]};
              sr_q   <= sr_q << 1;
              cnt_q  <= cnt_q - 6'd1;
            end
          end
        end

        ST_IDLE: begin
          if (req_i) begin
            we_q     <= we_i;
            addr_q   <= addr_i;
            wdata_q  <= wdata_i;
            nib_q    <= nibbles_for_bytes(eff_size);
            busy_q   <= 1'b1;
            ce_n_q   <= 1'b0;
            douten_q <= 4'hF;
            dout_q   <= cmd_sel[7:4];
            sr_q     <= cmd_al << 4;
            cnt_q    <= 6'd1;
            state_q  <= ST_CMD;
          end
        end

        ST_CMD: begin
          if (drive_en) begin
            if (cnt_q == 6'd0) begin
              state_q <= ST_ADDR;
              dout_q  <= addr_al[SR_W-1 -: 4];
              sr_q    <= addr_al << 4;
              cnt_q   <= 6'(ADDR_W / 4 - 1);
            end else begin
              dout_q <= sr_q[SR_W-1 -: 4];
              sr_q   <= sr_q << 4;
              cnt_q  <= cnt_q - 6'd1;
            end
          end
        end

        ST_ADDR: begin
          if (drive_en) begin
            if (cnt_q == 6'd0) begin
              if (we_q) begin
                state_q <= ST_DATA;
                dout_q  <= wstream[SR_W-1 -: 4];
                sr_q    <= wstream << 4;
                cnt_q   <= nib_q - 6'd1;
              end else begin
                douten_q <= '0;
                dout_q   <= '0;
                if (RD_DUMMY == 0) begin
                  state_q <= ST_DATA;
                  cnt_q   <= nib_q - 6'd1;
                  rdata_q <= '0;
                end else begin
                  state_q <= ST_DUMMY;
                  cnt_q   <= 6'(RD_DUMMY - 1);
                end
              end
            end else begin
              dout_q <= sr_q[SR_W-1 -: 4];
              sr_q   <= sr_q << 4;
              cnt_q  <= cnt_q - 6'd1;
            end
          end
        end

        ST_DUMMY: begin
          if (drive_en) begin
            if (cnt_q == 6'd0) begin
              // Old read data is dropped only when new data starts arriving
              state_q <= ST_DATA;
              cnt_q   <= nib_q - 6'd1;
              rdata_q <= '0;
            end else begin
              cnt_q <= cnt_q - 6'd1;
            end
          end
        end

        ST_DATA: begin
          if (sample_en && !we_q) begin
            for (int j = 0; j < 2 * MAX_BYTES; j++) begin
              if (rd_idx == 6'(j)) begin
                rdata_q[4*j +: 4] <= din_i;
              end
            end
          end
          if (drive_en) begin
            if (cnt_q == 6'd0) begin
              state_q  <= ST_GAP;
              ce_n_q   <= 1'b1;
              dout_q   <= '0;
              douten_q <= '0;
              done_q   <= 1'b1;
              cnt_q    <= 6'(CE_GAP - 1);
            end else begin
              cnt_q <= cnt_q - 6'd1;
              if (we_q) begin
                dout_q <= sr_q[SR_W-1 -: 4];
                sr_q   <= sr_q << 4;
              end
            end
          end
        end

        ST_GAP: begin
          if (cnt_q == 6'd0) begin
            state_q     <= ST_IDLE;
            busy_q      <= 1'b0;
            init_done_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 6'd1;
          end
        end

        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign rdata_o     = rdata_q;
  assign done_o      = done_q;
  assign busy_o      = busy_q;
  assign init_done_o = init_done_q;
  assign ce_n_o      = ce_n_q;
  assign dout_o      = dout_q;
  assign douten_o    = douten_q;

endmodule
`default_nettype wire
